// File: rtl/fetch_responder.sv
// Instruction fetch responder: a one-word tagged buffer in front of a variable-latency memory.
// Misses issue a single valid/ready request; flushes, bus errors and timeouts are absorbed here.
module fetch_responder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic        fetch_error,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_error
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              buf_valid_q, buf_valid_d;
    logic [29:0]       buf_tag_q, buf_tag_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              buf_err_q, buf_err_d;
    logic              stale_q, stale_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [29:0]       req_addr_q, req_addr_d;

    logic              hit;
    logic              timeout;
    logic              fill;
    logic [31:0]       fill_data;
    logic              fill_err;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^fetch_addr[1:0];

    assign hit         = buf_valid_q && (buf_tag_q == fetch_addr[31:2]) && !flush;
    assign fetch_ready = hit;
    assign fetch_error = hit && buf_err_q;
    assign fetch_data  = buf_data_q;

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = {req_addr_q, 2'b00};

    // cnt_q holds the number of completed WAIT cycles, so the current WAIT cycle is cnt_q+1
    assign timeout = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        buf_err_d   = buf_err_q;
        stale_d     = stale_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        fill        = 1'b0;
        fill_data   = 32'h0;
        fill_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hit && !flush) begin
                    req_addr_d = fetch_addr[31:2];
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (flush) stale_d = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (flush) stale_d = 1'b1;
                if (mem_resp_valid) begin
                    state_d   = IDLE;
                    stale_d   = 1'b0;
                    fill      = !stale_q && !flush;
                    fill_data = mem_resp_error ? 32'h0 : mem_resp_data;
                    fill_err  = mem_resp_error;
                end else if (timeout) begin
                    state_d   = DRAIN;
                    fill      = !stale_q && !flush;
                    fill_data = 32'h0;
                    fill_err  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // The late response of a timed-out request is swallowed here
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    stale_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fill) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = req_addr_q;
            buf_data_d  = fill_data;
            buf_err_d   = fill_err;
        end
        if (flush) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_err_q   <= 1'b0;
            stale_q     <= 1'b0;
            cnt_q       <= '0;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            buf_err_q   <= buf_err_d;
            stale_q     <= stale_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed scenarios followed by random traffic, all checked against
// a transaction-level model of the one-word buffer and the single outstanding memory request.
module tb_fetch_responder;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        fetch_error;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_error;

    fetch_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_addr    (fetch_addr),
        .fetch_data    (fetch_data),
        .fetch_ready   (fetch_ready),
        .fetch_error   (fetch_error),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .mem_resp_error(mem_resp_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    bit          drv_rst_n;
    logic [31:0] drv_addr;
    bit          drv_flush;
    int          ready_pct;
    int          lat_force;
    bit          use_fix;
    logic [31:0] fix_data;
    bit          fix_err;
    bit          spurious_en;

    // Reference model: buffer contents plus the one outstanding memory transaction
    bit          mb_valid;
    logic [29:0] mb_tag;
    logic [31:0] mb_data;
    bit          mb_err;
    bit          t_busy;
    bit          t_acc;
    bit          t_stale;
    logic [31:0] t_addr;
    int          t_acc_cyc;
    int          t_resp_cyc;
    int          cyc;

    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h200, 32'h300};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        mb_valid = 0; mb_tag = '0; mb_data = '0; mb_err = 0;
        t_busy = 0; t_acc = 0; t_stale = 0; t_addr = '0;
        t_acc_cyc = 0; t_resp_cyc = 0;
    endtask

    task automatic fill(input logic [31:0] d, input bit e);
        mb_valid = 1;
        mb_tag   = t_addr[31:2];
        mb_data  = d;
        mb_err   = e;
    endtask

    function automatic int pick_lat();
        if (lat_force > 0) return lat_force;
        if ($urandom_range(3) == 0) return int'($urandom_range(TO + 8, TO + 1));
        return int'($urandom_range(TO, 1));
    endfunction

    // One clock cycle: drive at the falling edge, check, advance the model, then the rising edge
    task automatic step();
        bit hit_exp, resp, tmo, in_time, busy_old, acc_old, stale_old;
        @(negedge clk);
        reset_n    = drv_rst_n;
        fetch_addr = drv_addr;
        flush      = drv_flush;
        mem_req_ready = (int'($urandom_range(99)) < ready_pct);
        resp = t_busy && t_acc && (cyc == t_resp_cyc);
        if (resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = use_fix ? fix_data : $urandom();
            mem_resp_error = use_fix ? fix_err : ($urandom_range(5) == 0);
        end else begin
            mem_resp_valid = spurious_en && !(t_busy && t_acc) && ($urandom_range(7) == 0);
            mem_resp_data  = $urandom();
            mem_resp_error = 1'($urandom_range(1));
        end
        #1;
        hit_exp = mb_valid && (mb_tag == fetch_addr[31:2]) && !flush;
        chk("fetch_ready", fetch_ready, hit_exp);
        chk("fetch_error", fetch_error, hit_exp && mb_err);
        chk("fetch_data", fetch_data, mb_data);
        chk("mem_req_valid", mem_req_valid, t_busy && !t_acc);
        if (t_busy && !t_acc) chk("mem_req_addr", mem_req_addr, t_addr);

        if (!drv_rst_n) begin
            clear_model();
        end else begin
            busy_old  = t_busy;
            acc_old   = t_acc;
            stale_old = t_stale;
            in_time   = busy_old && acc_old && (cyc - t_acc_cyc <= TO);
            tmo       = busy_old && acc_old && !resp && (cyc == t_acc_cyc + TO);
            if (busy_old && flush) t_stale = 1;
            if (resp) begin
                if (!stale_old && !flush && in_time)
                    fill(mem_resp_error ? 32'h0 : mem_resp_data, mem_resp_error);
                t_busy = 0;
                t_acc  = 0;
            end
            if (tmo && !stale_old && !flush) fill(32'h0, 1'b1);
            if (flush) mb_valid = 0;
            if (busy_old && !acc_old && mem_req_ready) begin
                t_acc      = 1;
                t_acc_cyc  = cyc;
                t_resp_cyc = cyc + pick_lat();
            end
            if (!busy_old && !hit_exp && !flush) begin
                t_busy  = 1;
                t_acc   = 0;
                t_stale = 0;
                t_addr  = {fetch_addr[31:2], 2'b00};
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        reset_n = 1'b1;
        fetch_addr = '0; flush = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0; mem_resp_error = 0;
        drv_rst_n = 0; drv_addr = '0; drv_flush = 0; ready_pct = 100; lat_force = 1;
        use_fix = 1; fix_data = '0; fix_err = 0; spurious_en = 0;
        clear_model();
        cyc = 0;

        #1 reset_n = 1'b0;
        #2;
        chk("rst_ready", fetch_ready, 0);
        chk("rst_error", fetch_error, 0);
        chk("rst_data", fetch_data, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        run(2);
        drv_rst_n = 1;

        // Miss then hold
        drv_addr = 32'h100; fix_data = 32'h00500093;
        step(); #2;
        chk("miss_req_valid", mem_req_valid, 1);
        chk("miss_req_addr", mem_req_addr, 32'h100);
        run(2); #2;
        chk("miss_ready_c3", fetch_ready, 1);
        chk("miss_data_c3", fetch_data, 32'h00500093);
        run(5); #2;
        chk("hold_no_req", mem_req_valid, 0);

        // Address change while the request is in flight
        drv_flush = 1; step(); drv_flush = 0;
        lat_force = 3; fix_data = 32'h11111111;
        run(3);
        drv_addr = 32'h200;
        run(2); #2;
        chk("inflight_not_ready", fetch_ready, 0);
        chk("inflight_idle", mem_req_valid, 0);
        lat_force = 1; fix_data = 32'h22222222;
        step(); #2;
        chk("inflight_req_valid", mem_req_valid, 1);
        chk("inflight_req_addr", mem_req_addr, 32'h200);
        run(2); #2;
        chk("inflight_ready", fetch_ready, 1);
        chk("inflight_data", fetch_data, 32'h22222222);

        // Flush while waiting for the response
        drv_addr = 32'h100; lat_force = 3; fix_data = 32'h33333333;
        run(2);
        drv_flush = 1; step(); drv_flush = 0;
        run(2); #2;
        chk("flush_discard", fetch_ready, 0);
        chk("flush_idle", mem_req_valid, 0);
        lat_force = 1; fix_data = 32'h44444444;
        step(); #2;
        chk("flush_rereq_valid", mem_req_valid, 1);
        chk("flush_rereq_addr", mem_req_addr, 32'h100);
        run(2); #2;
        chk("flush_ready", fetch_ready, 1);
        chk("flush_data", fetch_data, 32'h44444444);

        // Error response, then a good neighbour
        drv_addr = 32'h300; fix_err = 1; fix_data = 32'hDEADBEEF;
        run(3); #2;
        chk("err_ready", fetch_ready, 1);
        chk("err_flag", fetch_error, 1);
        chk("err_data", fetch_data, 32'h0);
        drv_addr = 32'h304; fix_err = 0; fix_data = 32'h55555555;
        run(3); #2;
        chk("good_ready", fetch_ready, 1);
        chk("good_flag", fetch_error, 0);
        chk("good_data", fetch_data, 32'h55555555);

        // Timeout then drain of the late response
        drv_addr = 32'h400; lat_force = TO + 10;
        run(2);
        run(TO); #2;
        chk("tmo_ready", fetch_ready, 1);
        chk("tmo_error", fetch_error, 1);
        chk("tmo_data", fetch_data, 32'h0);
        drv_addr = 32'h500;
        run(9); #2;
        chk("drain_no_req", mem_req_valid, 0);
        step(); #2;
        chk("drain_exit_no_req", mem_req_valid, 0);
        chk("drain_discard", fetch_data, 32'h0);
        lat_force = 1;
        step(); #2;
        chk("post_drain_req_valid", mem_req_valid, 1);
        chk("post_drain_req_addr", mem_req_addr, 32'h500);
        run(2); #2;
        chk("post_drain_ready", fetch_ready, 1);

        // Reset asserted while a request is stalled
        drv_addr = 32'h600; ready_pct = 0;
        run(2); #2;
        chk("rst_mid_req_pre", mem_req_valid, 1);
        reset_n = 1'b0; drv_rst_n = 0;
        #1;
        chk("rst_mid_ready", fetch_ready, 0);
        chk("rst_mid_error", fetch_error, 0);
        chk("rst_mid_data", fetch_data, 0);
        chk("rst_mid_req_valid", mem_req_valid, 0);
        chk("rst_mid_req_addr", mem_req_addr, 0);
        clear_model();
        run(2);
        drv_rst_n = 1; ready_pct = 100; fix_data = 32'h66666666;
        step(); #2;
        chk("rst_rel_req_valid", mem_req_valid, 1);
        chk("rst_rel_req_addr", mem_req_addr, 32'h600);
        run(2); #2;
        chk("rst_rel_ready", fetch_ready, 1);
        chk("rst_rel_data", fetch_data, 32'h66666666);

        // Random traffic
        use_fix = 0; lat_force = 0; spurious_en = 1; ready_pct = 60;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) drv_addr = pool[$urandom_range(3)] | 32'($urandom_range(3));
            drv_flush = ($urandom_range(19) == 0);
            step();
        end
        drv_flush = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
